video_pattern_source: RTL and testbench

- Raster timing generator and test-pattern transmitter that drives the RGB pixel stream into the CeNN input (R, G, B) for 1920x1080 timing (2200 x 1125 total).
- Generates data-enable, sync and start-of-frame markers so downstream preprocessing and the threshold stages can be exercised on-board without a camera.
- Pattern selection and run/stop control take effect only on frame boundaries.

---
 rtl/video_pattern_source_pkg.sv | 36 +++
 rtl/video_pattern_source_pattern_gen.sv | 63 ++++++
 rtl/video_pattern_source.sv | 144 ++++++++++++++
 tb/tb_video_pattern_source.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pattern_source_pkg.sv
// Shared types, default 1080p raster timing and the colour-bar table
// for the CeNN test-pattern source.
package cenn_video_pkg;

    typedef enum logic [1:0] {PAT_FLAT, PAT_RAMP, PAT_BARS, PAT_CHECK} pattern_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int def_h_active = 1920;
    localparam int def_h_front  = 88;
    localparam int def_h_sync   = 44;
    localparam int def_h_back   = 148;
    localparam int def_v_active = 1080;
    localparam int def_v_front  = 4;
    localparam int def_v_sync   = 5;
    localparam int def_v_back   = 36;

    localparam int h_total  = def_h_active + def_h_front + def_h_sync + def_h_back;
    localparam int v_total  = def_v_active + def_v_front + def_v_sync + def_v_back;
    localparam int hs_start = def_h_active + def_h_front;
    localparam int hs_end   = hs_start + def_h_sync - 1;
    localparam int vs_start = def_v_active + def_v_front;
    localparam int vs_end   = vs_start + def_v_sync - 1;

    // {R, G, B} full-scale flags: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] bar_table [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    localparam int ramp_shift = 32;

    // Rounded-up reciprocal keeps (n * recip) >> 32 equal to n / d for every ramp input.
    function automatic logic [63:0] ramp_recip(input int unsigned d);
        return ((64'd1 << ramp_shift) + 64'(d) - 64'd1) / 64'(d);
    endfunction

endpackage

// File: rtl/video_pattern_source_pattern_gen.sv
// Combinational pixel colour for one active position; the parent registers
// the result together with de and the sync outputs.
module pattern_gen
    import cenn_video_pkg::*;
#(
    parameter int width_RGB    = 8,
    parameter int h_active     = def_h_active,
    parameter int checker_log2 = 6
) (
    input  logic [10:0]          x,
    input  logic [10:0]          y,
    input  pattern_t             pat,
    input  logic [7:0]           frame_cnt,
    output logic [width_RGB-1:0] R,
    output logic [width_RGB-1:0] G,
    output logic [width_RGB-1:0] B
);

    localparam logic [63:0] max_val = 64'((1 << width_RGB) - 1);
    localparam logic [63:0] recip   = ramp_recip(h_active - 1);
    localparam int          bar_w   = h_active / 8;
    localparam logic [width_RGB-1:0] mid_grey = {1'b1, {(width_RGB-1){1'b0}}};

    logic [63:0]          ramp_prod;
    logic [width_RGB-1:0] ramp;
    logic [2:0]           bar_rgb;
    logic                 chk;

    always_comb begin
        // NOTE: every output gets a default first so no latch can be inferred.
        R = '0;
        G = '0;
        B = '0;
        ramp_prod = 64'(x) * max_val * recip;
        ramp      = width_RGB'(ramp_prod >> ramp_shift);
        bar_rgb   = bar_table[3'(x / 11'(bar_w))];
        chk       = 1'(((x + 11'(frame_cnt)) >> checker_log2) ^ (y >> checker_log2));
        case (pat)
            PAT_FLAT: begin
                R = mid_grey;
                G = mid_grey;
                B = mid_grey;
            end
            PAT_RAMP: begin
                R = ramp;
                G = ramp;
                B = ramp;
            end
            PAT_BARS: begin
                R = {width_RGB{bar_rgb[2]}};
                G = {width_RGB{bar_rgb[1]}};
                B = {width_RGB{bar_rgb[0]}};
            end
            PAT_CHECK: begin
                R = {width_RGB{chk}};
                G = {width_RGB{chk}};
                B = {width_RGB{chk}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/video_pattern_source.sv
// Raster timing generator and registered test-pattern pixel stream.
// Pattern selection and stop requests only take effect at frame boundaries.
module video_pattern_source
    import cenn_video_pkg::*;
#(
    parameter int width_RGB    = 8,
    parameter int h_active     = def_h_active,
    parameter int h_front      = def_h_front,
    parameter int h_sync       = def_h_sync,
    parameter int h_back       = def_h_back,
    parameter int v_active     = def_v_active,
    parameter int v_front      = def_v_front,
    parameter int v_sync       = def_v_sync,
    parameter int v_back       = def_v_back,
    parameter int checker_log2 = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           pattern_sel,
    output logic [width_RGB-1:0] R,
    output logic [width_RGB-1:0] G,
    output logic [width_RGB-1:0] B,
    output logic                 de,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 sof,
    output logic [10:0]          x,
    output logic [10:0]          y,
    output logic                 busy
);

    localparam logic [11:0] h_act    = 12'(h_active);
    localparam logic [11:0] v_act    = 12'(v_active);
    localparam logic [11:0] h_last   = 12'(h_active + h_front + h_sync + h_back - 1);
    localparam logic [11:0] v_last   = 12'(v_active + v_front + v_sync + v_back - 1);
    localparam logic [11:0] hs_first = 12'(h_active + h_front);
    localparam logic [11:0] hs_final = 12'(h_active + h_front + h_sync - 1);
    localparam logic [11:0] vs_first = 12'(v_active + v_front);
    localparam logic [11:0] vs_final = 12'(v_active + v_front + v_sync - 1);

    state_t               state;
    pattern_t             pat_q;
    logic [11:0]          h_cnt;
    logic [11:0]          v_cnt;
    logic [7:0]           frame_cnt;
    logic                 running;
    logic                 active;
    logic                 frame_end;
    logic [10:0]          px;
    logic [10:0]          py;
    logic [width_RGB-1:0] r_gen;
    logic [width_RGB-1:0] g_gen;
    logic [width_RGB-1:0] b_gen;

    always_comb begin
        running   = (state != IDLE);
        active    = running && (h_cnt < h_act) && (v_cnt < v_act);
        frame_end = running && (h_cnt == h_last) && (v_cnt == v_last);
        px        = active ? h_cnt[10:0] : '0;
        py        = active ? v_cnt[10:0] : '0;
    end

    pattern_gen #(
        .width_RGB    (width_RGB),
        .h_active     (h_active),
        .checker_log2 (checker_log2)
    ) u_pattern_gen (
        .x         (px),
        .y         (py),
        .pat       (pat_q),
        .frame_cnt (frame_cnt),
        .R         (r_gen),
        .G         (g_gen),
        .B         (b_gen)
    );

    // NOTE: all sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pat_q     <= PAT_FLAT;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            de        <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            sof       <= 1'b0;
            x         <= '0;
            y         <= '0;
            busy      <= 1'b0;
        end else begin
            de    <= active;
            hsync <= running && (h_cnt >= hs_first) && (h_cnt <= hs_final);
            vsync <= running && (v_cnt >= vs_first) && (v_cnt <= vs_final);
            sof   <= running && (h_cnt == '0) && (v_cnt == '0);
            x     <= px;
            y     <= py;
            R     <= active ? r_gen : '0;
            G     <= active ? g_gen : '0;
            B     <= active ? b_gen : '0;

            if (running) begin
                if (h_cnt == h_last) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == v_last) ? '0 : v_cnt + 12'd1;
                end else begin
                    h_cnt <= h_cnt + 12'd1;
                end
            end

            // Frame boundary: a wrap of both counters, or leaving IDLE.
            if (frame_end || (state == IDLE && en)) begin
                pat_q     <= pattern_t'(pattern_sel);
                frame_cnt <= frame_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    state <= en ? RUN : IDLE;
                    busy  <= en;
                end
                RUN: begin
                    state <= en ? RUN : DRAIN;
                    busy  <= 1'b1;
                end
                DRAIN: begin
                    if (en)             state <= RUN;
                    else if (frame_end) state <= IDLE;
                    busy <= en || !frame_end;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench for video_pattern_source on a reduced 16x8 raster:
// expected outputs are queued as each edge is driven and popped once it has passed.
module tb_video_pattern_source;

    localparam int W  = 8;
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VA = 8;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int CL = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   pattern_sel = 2'd0;
    logic [W-1:0] R, G, B;
    logic         de, hsync, vsync, sof, busy;
    logic [10:0]  x, y;

    video_pattern_source #(
        .width_RGB (W), .h_active (HA), .h_front (HF), .h_sync (HS), .h_back (HB),
        .v_active (VA), .v_front (VF), .v_sync (VS), .v_back (VB), .checker_log2 (CL)
    ) dut (
        .clk (clk), .rst_n (rst_n), .en (en), .pattern_sel (pattern_sel),
        .R (R), .G (G), .B (B), .de (de), .hsync (hsync), .vsync (vsync),
        .sof (sof), .x (x), .y (y), .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  r, g, b;
        logic        de, hs, vs, sof;
        logic [10:0] x, y;
        logic        busy;
    } obs_t;

    obs_t exp_q[$];
    int   n_assert = 0;
    int   n_fail = 0;

    // Reference model: 0 idle, 1 run, 2 drain.
    int m_state = 0;
    int m_h = 0;
    int m_v = 0;
    int m_frame = 0;
    int m_pat = 0;
    int exp_pat = 0;

    int sof_seen, de_seen, de_bursts, hs_seen, vs_seen;
    logic prev_de = 1'b0;

    function automatic logic [23:0] pixel(input int px, input int py, input int pat, input int fc);
        int idx;
        int c;
        case (pat)
            0: return 24'h808080;
            1: begin
                c = (px * 255) / (HA - 1);
                return {3{8'(c)}};
            end
            2: begin
                idx = px / (HA / 8);
                return {(idx[1] ? 8'h00 : 8'hFF), (idx[2] ? 8'h00 : 8'hFF), (idx[0] ? 8'h00 : 8'hFF)};
            end
            default: begin
                c = ((((px + fc) % 2048) >> CL) ^ (py >> CL)) & 1;
                return (c != 0) ? 24'hFFFFFF : 24'h000000;
            end
        endcase
    endfunction

    task automatic model_step(output obs_t e);
        bit last;
        e = '0;
        if (!rst_n) begin
            m_state = 0; m_h = 0; m_v = 0; m_frame = 0; m_pat = 0;
            return;
        end
        exp_pat = m_pat;
        if (m_state != 0) begin
            e.de  = (m_h < HA) && (m_v < VA);
            e.hs  = (m_h >= HA + HF) && (m_h < HA + HF + HS);
            e.vs  = (m_v >= VA + VF) && (m_v < VA + VF + VS);
            e.sof = (m_h == 0) && (m_v == 0);
            if (e.de) begin
                e.x = 11'(m_h);
                e.y = 11'(m_v);
                {e.r, e.g, e.b} = pixel(m_h, m_v, m_pat, m_frame);
            end
        end
        if (m_state == 0) begin
            if (en) begin
                m_state = 1;
                m_pat   = int'(pattern_sel);
                m_frame = (m_frame + 1) % 256;
            end
        end else begin
            last = (m_h == HT - 1) && (m_v == VT - 1);
            m_h = m_h + 1;
            if (m_h == HT) begin
                m_h = 0;
                m_v = (m_v + 1) % VT;
            end
            if (last) begin
                m_pat   = int'(pattern_sel);
                m_frame = (m_frame + 1) % 256;
            end
            if (en)                m_state = 1;
            else if (m_state == 1) m_state = 2;
            else if (last)         m_state = 0;
        end
        e.busy = (m_state != 0);
    endtask

    task automatic spot(input string tag, input logic [23:0] obs, input logic [23:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic count_check(input string tag, input int obs, input int want);
        n_assert++;
        assert (obs == want) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic tick(input string tag);
        obs_t e;
        obs_t a;
        model_step(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a = {R, G, B, de, hsync, vsync, sof, x, y, busy};
        e = exp_q.pop_front();
        n_assert++;
        assert (a === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, a, e);
        end
        if (e.de && exp_pat == 2 && e.x == 11'd0)        spot({tag, "_bar_white"}, {R, G, B}, 24'hFFFFFF);
        if (e.de && exp_pat == 2 && e.x == 11'(HA / 8)) spot({tag, "_bar_yellow"}, {R, G, B}, 24'hFFFF00);
        if (e.de && exp_pat == 2 && e.x == 11'(HA - 1)) spot({tag, "_bar_black"}, {R, G, B}, 24'h000000);
        if (e.de && exp_pat == 1 && e.x == 11'd0)        spot({tag, "_ramp_lo"}, {R, G, B}, 24'h000000);
        if (e.de && exp_pat == 1 && e.x == 11'(HA - 1)) spot({tag, "_ramp_hi"}, {R, G, B}, 24'hFFFFFF);
        if (e.de && exp_pat == 0 && e.x == 11'(HA / 2)) spot({tag, "_flat"}, {R, G, B}, 24'h808080);
        sof_seen  += int'(sof);
        de_seen   += int'(de);
        hs_seen   += int'(hsync);
        vs_seen   += int'(vsync);
        de_bursts += int'(de && !prev_de);
        prev_de = de;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic clear_counts();
        sof_seen = 0; de_seen = 0; de_bursts = 0; hs_seen = 0; vs_seen = 0;
    endtask

    initial begin
        clear_counts();
        rst_n = 1'b0; en = 1'b0; pattern_sel = 2'd2;
        run(3, "reset");
        rst_n = 1'b1;
        run(2, "idle_hold");

        // Frame 1: colour bars, full-frame timing counts.
        en = 1'b1;
        clear_counts();
        run(1 + FR, "frame_bars");
        count_check("sof_per_frame", sof_seen, 1);
        count_check("de_per_frame", de_seen, HA * VA);
        count_check("de_bursts", de_bursts, VA);
        count_check("hsync_cycles", hs_seen, HS * VT);
        count_check("vsync_cycles", vs_seen, VS * HT);

        // Mid-frame selection changes stay invisible until the next frame.
        run(FR / 2, "bars_head");
        pattern_sel = 2'd1;
        run(FR / 2, "bars_tail");
        run(FR / 2, "ramp_head");
        pattern_sel = 2'd0;
        run(FR / 2, "ramp_tail");
        run(FR / 2, "flat_head");
        pattern_sel = 2'd3;
        run(FR / 2, "flat_tail");
        run(FR, "checker_a");
        run(FR, "checker_b");

        // Brief drop and return of en, then a real stop at line 4.
        pattern_sel = 2'd2;
        run(HT * 3, "pre_drain");
        en = 1'b0;
        run(5, "drain_short");
        en = 1'b1;
        run(4, "drain_rejoin");
        run(HT, "rerun");
        en = 1'b0;
        run(FR, "drain_to_idle");
        count_check("busy_after_drain", int'(busy), 0);

        clear_counts();
        en = 1'b1;
        run(3, "restart");
        count_check("restart_sof", sof_seen, 1);

        // Synchronous reset in mid-line with en held high.
        run(HT * 2 + 7, "pre_reset");
        rst_n = 1'b0;
        run(1, "mid_reset");
        rst_n = 1'b1;
        clear_counts();
        run(FR, "after_reset");
        count_check("after_reset_sof", sof_seen, 1);
        count_check("after_reset_de", de_seen, HA * VA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
